ni_packetizer: RTL

- Network-interface injection stage; sits directly upstream of the router switch controller's NI input.
- Accepts packet requests (destination plus payload length) and a 6-bit payload stream from the local core.
- Serialises each packet into 8-bit flits: one head, zero or more body flits, one tail.
- Drives the router's NI flit input and obeys the router's noc_ready back-pressure.

---
 rtl/noc_pkg.sv | 27 ++
 rtl/ni_packetizer_if.sv | 35 +++
 rtl/ni_packetizer.sv | 117 +++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC flit encoding, widths and NI state type.
// Used by the NI packetizer and the router switch controller.
package noc_pkg;

  localparam int FLIT_W = 8;
  localparam int NODE_W = 2;

  localparam logic [5:0]        HEAD_TAG  = 6'b111111;
  localparam logic [1:0]        BODY_TAG  = 2'b10;
  localparam logic [1:0]        TAIL_TAG  = 2'b01;
  localparam logic [FLIT_W-1:0] IDLE_FLIT = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    BODY,
    WAIT
  } ni_state;

  function automatic logic [FLIT_W-1:0] data_flit(
    input logic       last,
    input logic [5:0] d
  );
    return {last ? TAIL_TAG : BODY_TAG, d};
  endfunction

endpackage

// File: rtl/ni_packetizer_if.sv
// Core-side request/payload handshakes and router-side flit port
// of the NI packetizer; master = core/router side, slave = packetizer.
interface ni_packetizer_if #(
  parameter int LEN_W = 4
);
  import noc_pkg::*;

  logic              pkt_valid;
  logic              pkt_ready;
  logic [NODE_W-1:0] pkt_dest;
  logic [LEN_W-1:0]  pkt_len;
  logic              data_valid;
  logic              data_ready;
  logic [5:0]        data_in;
  logic              noc_ready;
  logic [FLIT_W-1:0] flit_out;
  logic              busy;
  logic              pkt_done;
  logic              len_err;

  modport master (
    output pkt_valid, pkt_dest, pkt_len,
    output data_valid, data_in, noc_ready,
    input  pkt_ready, data_ready, flit_out,
    input  busy, pkt_done, len_err
  );

  modport slave (
    input  pkt_valid, pkt_dest, pkt_len,
    input  data_valid, data_in, noc_ready,
    output pkt_ready, data_ready, flit_out,
    output busy, pkt_done, len_err
  );

endinterface

// File: rtl/ni_packetizer.sv
// NI injection stage: serialises requests into head/body/tail flits.
// Optional NI_PKT_CNT_EN adds a 16-bit completed-packet counter.
module ni_packetizer
  import noc_pkg::*;
#(
  parameter int LEN_W   = 4,
  parameter int MAX_LEN = 15
) (
  input  logic clk,
  input  logic rst,
  ni_packetizer_if.slave bus
`ifdef NI_PKT_CNT_EN
  ,
  output logic [15:0] pkt_cnt
`endif
);

  ni_state           state, state_n;
  logic [LEN_W-1:0]  rem, rem_n;
  logic [FLIT_W-1:0] flit, flit_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              err_q, err_n;
  logic              accept;
  logic              len_ok;

  assign accept = (flit != IDLE_FLIT) && bus.noc_ready;
  assign len_ok = (bus.pkt_len != '0) &&
                  (int'(bus.pkt_len) <= MAX_LEN);

  always_comb begin
    state_n        = state;
    rem_n          = rem;
    flit_n         = flit;
    busy_n         = busy_q;
    done_n         = 1'b0;
    err_n          = 1'b0;
    bus.pkt_ready  = 1'b0;
    bus.data_ready = 1'b0;
    unique case (state)
      IDLE: begin
        bus.pkt_ready = 1'b1;
        if (bus.pkt_valid) begin
          if (len_ok) begin
            rem_n   = bus.pkt_len;
            flit_n  = {HEAD_TAG, bus.pkt_dest};
            busy_n  = 1'b1;
            state_n = HEAD;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      HEAD, BODY: begin
        bus.data_ready = bus.noc_ready && (rem != '0);
        if (accept) begin
          if (rem == '0) begin
            flit_n  = IDLE_FLIT;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
          end else if (bus.data_valid) begin
            flit_n  = data_flit(rem == LEN_W'(1), bus.data_in);
            rem_n   = rem - LEN_W'(1);
            state_n = BODY;
          end else begin
            flit_n  = IDLE_FLIT;
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        bus.data_ready = 1'b1;
        if (bus.data_valid) begin
          flit_n  = data_flit(rem == LEN_W'(1), bus.data_in);
          rem_n   = rem - LEN_W'(1);
          state_n = BODY;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rem    <= '0;
      flit   <= IDLE_FLIT;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      rem    <= rem_n;
      flit   <= flit_n;
      busy_q <= busy_n;
      done_q <= done_n;
      err_q  <= err_n;
    end
  end

  assign bus.flit_out = flit;
  assign bus.busy     = busy_q;
  assign bus.pkt_done = done_q;
  assign bus.len_err  = err_q;

`ifdef NI_PKT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else if (done_q) begin
      pkt_cnt <= pkt_cnt + 16'd1;
    end
  end
`endif

endmodule
